id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 156 +++++++++++++++
 tb/tb_id_ex_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-control decode, EX/MEM and MEM/WB operand
// forwarding, and load-use hazard detection for a 32-bit single-issue pipeline.
module id_ex_stage (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   input  logic        i_stall,
   input  logic        i_flush,
   input  logic [31:0] i_rs_data,
   input  logic [31:0] i_rt_data,
   input  logic [31:0] i_imm,
   input  logic [4:0]  i_rs_addr,
   input  logic [4:0]  i_rt_addr,
   input  logic [4:0]  i_wr_addr,
   input  logic [1:0]  i_alu_op,
   input  logic [5:0]  i_funct,
   input  logic        i_alu_src,
   input  logic [3:0]  i_wb_ctrl,
   input  logic        i_exmem_we,
   input  logic [4:0]  i_exmem_rd,
   input  logic [31:0] i_exmem_data,
   input  logic        i_memwb_we,
   input  logic [4:0]  i_memwb_rd,
   input  logic [31:0] i_memwb_data,
   output logic        o_valid,
   output logic [31:0] o_op1,
   output logic [31:0] o_op2,
   output logic [3:0]  o_control,
   output logic [31:0] o_store_data,
   output logic [4:0]  o_wr_addr,
   output logic [3:0]  o_wb_ctrl,
   output logic        o_hazard
);

   localparam logic [3:0] CTRL_ADD = 4'b0010;

   function automatic logic [3:0] alu_decode(input logic [1:0] alu_op, input logic [5:0] funct);
      logic [3:0] ctrl;
      case (alu_op)
         2'b00:   ctrl = 4'b0010;
         2'b01:   ctrl = 4'b0110;
         2'b11:   ctrl = 4'b0001;
         2'b10: begin
            case (funct)
               6'b100000: ctrl = 4'b0010;
               6'b100010: ctrl = 4'b0110;
               6'b100100: ctrl = 4'b0000;
               6'b100101: ctrl = 4'b0001;
               6'b100111: ctrl = 4'b1100;
               6'b101010: ctrl = 4'b0111;
               default:   ctrl = 4'b1111;
            endcase
         end
         default: ctrl = 4'b1111;
      endcase
      return ctrl;
   endfunction

   // The younger producer (EX/MEM) takes precedence; register 0 never matches.
   function automatic logic [31:0] forward(
      input logic [4:0]  idx,
      input logic [31:0] rf_data,
      input logic        exmem_we,
      input logic [4:0]  exmem_rd,
      input logic [31:0] exmem_data,
      input logic        memwb_we,
      input logic [4:0]  memwb_rd,
      input logic [31:0] memwb_data
   );
      logic [31:0] val;
      if (exmem_we && (exmem_rd != 5'd0) && (exmem_rd == idx)) begin
         val = exmem_data;
      end else if (memwb_we && (memwb_rd != 5'd0) && (memwb_rd == idx)) begin
         val = memwb_data;
      end else begin
         val = rf_data;
      end
      return val;
   endfunction

   logic        valid_r;
   logic [31:0] rs_data_r;
   logic [31:0] rt_data_r;
   logic [31:0] imm_r;
   logic [4:0]  rs_addr_r;
   logic [4:0]  rt_addr_r;
   logic [4:0]  wr_addr_r;
   logic        alu_src_r;
   logic [3:0]  control_r;
   logic [3:0]  wb_ctrl_r;

   logic        hazard_s;
   logic [31:0] rs_fwd_s;
   logic [31:0] rt_fwd_s;

   // Load-use detection against the instruction currently held in the stage
   always_comb begin
      hazard_s = 1'b0;
      if (i_valid && valid_r && wb_ctrl_r[1] && (wr_addr_r != 5'd0) &&
          ((wr_addr_r == i_rs_addr) || (wr_addr_r == i_rt_addr)) &&
          !i_stall && !i_flush) begin
         hazard_s = 1'b1;
      end else begin
         hazard_s = 1'b0;
      end
   end

   // Stage register: reset > flush > stall hold > hazard bubble > capture/bubble
   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush || (!i_stall && (hazard_s || !i_valid))) begin
         valid_r   <= 1'b0;
         rs_data_r <= 32'd0;
         rt_data_r <= 32'd0;
         imm_r     <= 32'd0;
         rs_addr_r <= 5'd0;
         rt_addr_r <= 5'd0;
         wr_addr_r <= 5'd0;
         alu_src_r <= 1'b0;
         control_r <= CTRL_ADD;
         wb_ctrl_r <= 4'd0;
      end else if (!i_stall) begin
         valid_r   <= 1'b1;
         rs_data_r <= i_rs_data;
         rt_data_r <= i_rt_data;
         imm_r     <= i_imm;
         rs_addr_r <= i_rs_addr;
         rt_addr_r <= i_rt_addr;
         wr_addr_r <= i_wr_addr;
         alu_src_r <= i_alu_src;
         control_r <= alu_decode(i_alu_op, i_funct);
         wb_ctrl_r <= i_wb_ctrl;
      end
   end

   // Forwarding stays live while the stage holds, so operands track producers
   always_comb begin
      rs_fwd_s = forward(rs_addr_r, rs_data_r, i_exmem_we, i_exmem_rd, i_exmem_data,
                         i_memwb_we, i_memwb_rd, i_memwb_data);
      rt_fwd_s = forward(rt_addr_r, rt_data_r, i_exmem_we, i_exmem_rd, i_exmem_data,
                         i_memwb_we, i_memwb_rd, i_memwb_data);
      if (alu_src_r) begin
         o_op2 = imm_r;
      end else begin
         o_op2 = rt_fwd_s;
      end
   end

   assign o_valid      = valid_r;
   assign o_op1        = rs_fwd_s;
   assign o_store_data = rt_fwd_s;
   assign o_control    = control_r;
   assign o_wr_addr    = wr_addr_r;
   assign o_wb_ctrl    = valid_r ? wb_ctrl_r : 4'd0;
   assign o_hazard     = hazard_s;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by random
// traffic, compared against a transaction-level model of the stage.
module tb_id_ex_stage;

   logic        i_clk = 1'b0;
   logic        i_rst, i_valid, i_stall, i_flush;
   logic [31:0] i_rs_data, i_rt_data, i_imm;
   logic [4:0]  i_rs_addr, i_rt_addr, i_wr_addr;
   logic [1:0]  i_alu_op;
   logic [5:0]  i_funct;
   logic        i_alu_src;
   logic [3:0]  i_wb_ctrl;
   logic        i_exmem_we, i_memwb_we;
   logic [4:0]  i_exmem_rd, i_memwb_rd;
   logic [31:0] i_exmem_data, i_memwb_data;
   logic        o_valid, o_hazard;
   logic [31:0] o_op1, o_op2, o_store_data;
   logic [3:0]  o_control, o_wb_ctrl;
   logic [4:0]  o_wr_addr;

   always #5 i_clk = ~i_clk;

   id_ex_stage dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_stall(i_stall), .i_flush(i_flush),
      .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_imm(i_imm),
      .i_rs_addr(i_rs_addr), .i_rt_addr(i_rt_addr), .i_wr_addr(i_wr_addr),
      .i_alu_op(i_alu_op), .i_funct(i_funct), .i_alu_src(i_alu_src), .i_wb_ctrl(i_wb_ctrl),
      .i_exmem_we(i_exmem_we), .i_exmem_rd(i_exmem_rd), .i_exmem_data(i_exmem_data),
      .i_memwb_we(i_memwb_we), .i_memwb_rd(i_memwb_rd), .i_memwb_data(i_memwb_data),
      .o_valid(o_valid), .o_op1(o_op1), .o_op2(o_op2), .o_control(o_control),
      .o_store_data(o_store_data), .o_wr_addr(o_wr_addr), .o_wb_ctrl(o_wb_ctrl),
      .o_hazard(o_hazard)
   );

   // Instruction held in the stage, as seen at the transaction level
   typedef struct {
      bit          valid;
      logic [31:0] rs_data, rt_data, imm;
      logic [4:0]  rs_addr, rt_addr, wr_addr;
      bit          alu_src;
      logic [3:0]  ctrl, wb;
   } instr_t;

   localparam logic [5:0] FUNCT_TBL [6] = '{6'b100000, 6'b100010, 6'b100100,
                                            6'b100101, 6'b100111, 6'b101010};
   localparam logic [3:0] CTRL_TBL  [6] = '{4'b0010, 4'b0110, 4'b0000,
                                            4'b0001, 4'b1100, 4'b0111};

   instr_t m;
   int n_checks = 0;
   int n_fail   = 0;

   function automatic instr_t bubble();
      instr_t b;
      b.valid = 1'b0; b.rs_data = 32'd0; b.rt_data = 32'd0; b.imm = 32'd0;
      b.rs_addr = 5'd0; b.rt_addr = 5'd0; b.wr_addr = 5'd0; b.alu_src = 1'b0;
      b.ctrl = 4'b0010; b.wb = 4'd0;
      return b;
   endfunction

   function automatic logic [3:0] ref_ctrl(logic [1:0] op, logic [5:0] f);
      if (op == 2'b00) return 4'b0010;
      if (op == 2'b01) return 4'b0110;
      if (op == 2'b11) return 4'b0001;
      for (int k = 0; k < 6; k++) begin
         if (FUNCT_TBL[k] == f) return CTRL_TBL[k];
      end
      return 4'b1111;
   endfunction

   // Newest in-flight producer of a nonzero register supplies its value
   function automatic logic [31:0] ref_operand(logic [4:0] idx, logic [31:0] rf);
      if (idx == 5'd0) return rf;
      if (i_exmem_we && i_exmem_rd == idx) return i_exmem_data;
      if (i_memwb_we && i_memwb_rd == idx) return i_memwb_data;
      return rf;
   endfunction

   function automatic bit ref_hazard();
      return i_valid && m.valid && m.wb[1] && (m.wr_addr != 5'd0) &&
             ((m.wr_addr == i_rs_addr) || (m.wr_addr == i_rt_addr)) && !i_stall && !i_flush;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(string tag);
      chk({tag, ".valid"}, {31'd0, o_valid}, {31'd0, m.valid});
      chk({tag, ".op1"}, o_op1, ref_operand(m.rs_addr, m.rs_data));
      chk({tag, ".op2"}, o_op2, m.alu_src ? m.imm : ref_operand(m.rt_addr, m.rt_data));
      chk({tag, ".store"}, o_store_data, ref_operand(m.rt_addr, m.rt_data));
      chk({tag, ".ctrl"}, {28'd0, o_control}, {28'd0, m.ctrl});
      chk({tag, ".wr_addr"}, {27'd0, o_wr_addr}, {27'd0, m.wr_addr});
      chk({tag, ".wb"}, {28'd0, o_wb_ctrl}, {28'd0, m.valid ? m.wb : 4'd0});
      chk({tag, ".hazard"}, {31'd0, o_hazard}, {31'd0, ref_hazard()});
   endtask

   // Optionally check settled outputs, advance the model, clock once, check again
   task automatic step(string tag, bit pre);
      bit haz;
      #1;
      if (pre) check_all({tag, "/pre"});
      haz = ref_hazard();
      if (i_rst || i_flush) m = bubble();
      else if (i_stall) m = m;
      else if (haz || !i_valid) m = bubble();
      else begin
         m.valid = 1'b1; m.rs_data = i_rs_data; m.rt_data = i_rt_data; m.imm = i_imm;
         m.rs_addr = i_rs_addr; m.rt_addr = i_rt_addr; m.wr_addr = i_wr_addr;
         m.alu_src = i_alu_src; m.ctrl = ref_ctrl(i_alu_op, i_funct); m.wb = i_wb_ctrl;
      end
      @(posedge i_clk);
      #1;
      check_all({tag, "/post"});
   endtask

   task automatic set_instr(logic [4:0] rsa, logic [31:0] rsd, logic [4:0] rta, logic [31:0] rtd,
                            logic [31:0] imm, logic [4:0] wr, logic [1:0] op, logic [5:0] f,
                            logic src, logic [3:0] wb);
      i_valid = 1'b1; i_rs_addr = rsa; i_rs_data = rsd; i_rt_addr = rta; i_rt_data = rtd;
      i_imm = imm; i_wr_addr = wr; i_alu_op = op; i_funct = f; i_alu_src = src; i_wb_ctrl = wb;
   endtask

   task automatic no_fwd();
      i_exmem_we = 1'b0; i_exmem_rd = 5'd0; i_exmem_data = 32'd0;
      i_memwb_we = 1'b0; i_memwb_rd = 5'd0; i_memwb_data = 32'd0;
   endtask

   initial begin
      logic [31:0] held;
      m = bubble();
      i_rst = 1'b1; i_stall = 1'b0; i_flush = 1'b0;
      set_instr(5'd1, 32'h1, 5'd2, 32'h2, 32'h3, 5'd4, 2'b10, 6'b100000, 1'b0, 4'b1000);
      no_fwd();
      step("reset", 1'b0);
      chk("reset.ctrl_const", {28'd0, o_control}, 32'h2);
      chk("reset.op1_const", o_op1, 32'h0);
      i_rst = 1'b0;

      // R-type add without forwarding
      set_instr(5'd5, 32'h10, 5'd6, 32'h20, 32'h0, 5'd7, 2'b10, 6'b100000, 1'b0, 4'b1000);
      step("add", 1'b1);
      chk("add.op1_const", o_op1, 32'h10);
      chk("add.op2_const", o_op2, 32'h20);

      // Forwarding priority on a held rs=3 instruction
      set_instr(5'd3, 32'h33, 5'd9, 32'h99, 32'h0, 5'd8, 2'b10, 6'b100010, 1'b0, 4'b1000);
      step("cap_rs3", 1'b1);
      i_stall = 1'b1;
      i_exmem_we = 1'b1; i_exmem_rd = 5'd3; i_exmem_data = 32'hAA;
      i_memwb_we = 1'b1; i_memwb_rd = 5'd3; i_memwb_data = 32'hBB;
      #1 chk("fwd.exmem_const", o_op1, 32'hAA);
      check_all("fwd.exmem");
      i_exmem_rd = 5'd0;
      #1 chk("fwd.memwb_const", o_op1, 32'hBB);
      step("fwd.hold", 1'b1);
      i_stall = 1'b0; no_fwd();

      // Load-use hazard inserts one bubble
      set_instr(5'd1, 32'h11, 5'd2, 32'h22, 32'h8, 5'd4, 2'b00, 6'b000000, 1'b1, 4'b1110);
      step("lw", 1'b1);
      set_instr(5'd7, 32'h77, 5'd4, 32'h44, 32'h0, 5'd9, 2'b10, 6'b100000, 1'b0, 4'b1000);
      #1 chk("haz.raise", {31'd0, o_hazard}, 32'd1);
      step("haz.bubble", 1'b1);
      chk("haz.valid0", {31'd0, o_valid}, 32'd0);
      chk("haz.clear", {31'd0, o_hazard}, 32'd0);
      step("haz.retry", 1'b1);

      // Funct decode corners
      set_instr(5'd1, 32'h5, 5'd2, 32'h6, 32'h0, 5'd3, 2'b10, 6'b101010, 1'b0, 4'b1000);
      step("slt", 1'b1);
      chk("slt.ctrl_const", {28'd0, o_control}, 32'h7);
      i_funct = 6'b000000;
      step("badfunct", 1'b1);
      chk("badfunct.ctrl_const", {28'd0, o_control}, 32'hF);

      // Stall holds for two cycles, then flush overrides stall
      held = o_op1;
      i_stall = 1'b1;
      set_instr(5'd6, 32'hDEAD, 5'd7, 32'hBEEF, 32'h1, 5'd2, 2'b01, 6'b0, 1'b1, 4'b0001);
      step("stall1", 1'b1);
      step("stall2", 1'b1);
      chk("stall.op1_const", o_op1, held);
      i_flush = 1'b1;
      step("flush_stall", 1'b1);
      i_flush = 1'b0; i_stall = 1'b0;

      // Reset while a valid instruction is held under stall
      set_instr(5'd2, 32'h1234, 5'd3, 32'h5678, 32'h9, 5'd5, 2'b11, 6'b0, 1'b0, 4'b1100);
      step("cap_pre_rst", 1'b1);
      i_stall = 1'b1; i_rst = 1'b1;
      step("rst_stall", 1'b1);
      chk("rst_stall.valid0", {31'd0, o_valid}, 32'd0);
      i_rst = 1'b0; i_stall = 1'b0;

      // Random traffic over a small register window to provoke matches
      for (int n = 0; n < 400; n++) begin
         i_rst   = ($urandom_range(0, 63) == 0);
         i_flush = ($urandom_range(0, 15) == 0);
         i_stall = ($urandom_range(0, 5) == 0);
         set_instr(5'($urandom_range(0, 7)), $urandom(), 5'($urandom_range(0, 7)), $urandom(),
                   $urandom(), 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                   ($urandom_range(0, 1) == 1) ? FUNCT_TBL[$urandom_range(0, 5)]
                                               : 6'($urandom_range(0, 63)),
                   1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
         i_valid      = ($urandom_range(0, 3) != 0);
         i_exmem_we   = 1'($urandom_range(0, 1));
         i_exmem_rd   = 5'($urandom_range(0, 7));
         i_exmem_data = $urandom();
         i_memwb_we   = 1'($urandom_range(0, 1));
         i_memwb_rd   = 5'($urandom_range(0, 7));
         i_memwb_data = $urandom();
         step("rand", 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
